// File: rtl/alu_accumulator.sv
// alu_accumulator: this block drives an external 16-bit flag-producing ALU.
// It sums a run of `len` operands, which arrive over a valid/ready handshake.
// The sum is returned together with sticky carry/overflow flags and a zero flag.
module alu_accumulator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_ovf,
    output logic             res_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [LEN_W-1:0] remaining_q;
    logic             carry_st_q;
    logic             ovf_st_q;

    logic             in_ready_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_sum_q;
    logic             res_carry_q;
    logic             res_ovf_q;
    logic             res_zero_q;
    logic             busy_q;

    // Flag values after the current accept; feed both the sticky state and the result.
    logic             accept_c;
    logic             carry_next_c;
    logic             ovf_next_c;

    // The ALU sees the running sum and the presented operand directly.
    assign alu_x = acc_q;
    assign alu_y = in_data;

    // Accept qualification and flag merge for this cycle.
    always_comb begin
        accept_c     = 1'b0;
        carry_next_c = carry_st_q;
        ovf_next_c   = ovf_st_q;
        if (state_q == ST_ACCUM) begin
            accept_c = in_valid & in_ready_q;
        end
        if (accept_c) begin
            carry_next_c = carry_st_q | alu_carry;
            ovf_next_c   = ovf_st_q | alu_overflow;
        end
    end

    // Sequencer: state, datapath and registered outputs.
    // Outputs are set here for the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            carry_st_q  <= 1'b0;
            ovf_st_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q       <= '0;
                        carry_st_q  <= 1'b0;
                        ovf_st_q    <= 1'b0;
                        remaining_q <= len;
                        busy_q      <= 1'b1;
                        if (len != '0) begin
                            state_q    <= ST_ACCUM;
                            in_ready_q <= 1'b1;
                        end else begin
                            // Empty run: present a zero result right away.
                            state_q     <= ST_DONE;
                            res_valid_q <= 1'b1;
                            res_sum_q   <= '0;
                            res_carry_q <= 1'b0;
                            res_ovf_q   <= 1'b0;
                            res_zero_q  <= 1'b1;
                        end
                    end
                end

                ST_ACCUM: begin
                    if (accept_c) begin
                        acc_q       <= alu_out;
                        carry_st_q  <= carry_next_c;
                        ovf_st_q    <= ovf_next_c;
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q     <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            res_valid_q <= 1'b1;
                            res_sum_q   <= alu_out;
                            res_carry_q <= carry_next_c;
                            res_ovf_q   <= ovf_next_c;
                            res_zero_q  <= (alu_out == '0);
                        end
                    end
                end

                ST_DONE: begin
                    // Result is held until it is taken. start is ignored here.
                    if (res_ready) begin
                        state_q     <= ST_IDLE;
                        res_valid_q <= 1'b0;
                        res_sum_q   <= '0;
                        res_carry_q <= 1'b0;
                        res_ovf_q   <= 1'b0;
                        res_zero_q  <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                    res_sum_q   <= '0;
                    res_carry_q <= 1'b0;
                    res_ovf_q   <= 1'b0;
                    res_zero_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_carry = res_carry_q;
    assign res_ovf   = res_ovf_q;
    assign res_zero  = res_zero_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// Testbench for alu_accumulator.
// Stimulus pushes the expected results into a queue. A monitor compares each
// result at the handshake and checks that outputs are gated while idle.
module tb_alu_accumulator;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned LEN_W = 8;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
        logic             zero;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;
    logic             alu_overflow;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_carry;
    logic             res_ovf;
    logic             res_zero;
    logic             busy;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    res_t exp_q[$];

    alu_accumulator #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len          (len),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_out      (alu_out),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_sum      (res_sum),
        .res_carry    (res_carry),
        .res_ovf      (res_ovf),
        .res_zero     (res_zero),
        .busy         (busy)
    );

    // External ALU: a 16-bit adder that produces carry and signed overflow.
    assign {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
    assign alu_overflow = (alu_x[WIDTH-1] == alu_y[WIDTH-1]) && (alu_out[WIDTH-1] != alu_x[WIDTH-1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] s, input logic c, input logic o);
        res_t r;
        r.sum   = s;
        r.carry = c;
        r.ovf   = o;
        r.zero  = (s == '0);
        exp_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Present an operand after `gap` idle cycles and wait, up to a bounded time, for it to be accepted.
    task automatic send(input logic [WIDTH-1:0] d, input int gap);
        bit done;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d;
        done     = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: operand 0x%0h was never accepted", d);
        end
        in_valid = 1'b0;
    endtask

    // Monitor: checks each result at the handshake, and the output gating while no result is valid.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_result: got sum 0x%0h with no expectation", res_sum);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_sum", 32'(res_sum), 32'(e.sum));
                        check("res_carry", 32'(res_carry), 32'(e.carry));
                        check("res_ovf", 32'(res_ovf), 32'(e.ovf));
                        check("res_zero", 32'(res_zero), 32'(e.zero));
                    end
                end else if (!res_valid) begin
                    check("gated_outputs", {13'd0, res_sum, res_carry, res_ovf, res_zero}, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_outputs", {12'd0, res_sum, in_ready, res_valid, res_carry, res_ovf, res_zero, busy}, 32'd0);
        check("reset_acc", 32'(alu_x), 32'd0);
        mon_en = 1'b1;
        tick();

        // Test 1: 1 + 2 + 3, operands back-to-back.
        push_exp(16'h0006, 1'b0, 1'b0);
        start_run(8'd3);
        check("t1_in_ready_after_start", 32'(in_ready), 32'd1);
        send(16'h0001, 0);
        send(16'h0002, 0);
        check("t1_alu_y_passthrough", 32'(alu_y), 32'(in_data));
        send(16'h0003, 0);
        check("t1_res_valid_latency", 32'(res_valid), 32'd1);
        tick();

        // Test 2: 0xFFFF + 1 wraps to zero with a carry.
        push_exp(16'h0000, 1'b1, 1'b0);
        start_run(8'd2);
        send(16'hFFFF, 0);
        send(16'h0001, 0);
        tick();

        // Test 3: the flags are sticky across the steps of a run.
        push_exp(16'h0000, 1'b1, 1'b1);
        start_run(8'd3);
        send(16'h7FFF, 0);
        send(16'h0001, 0);
        check("t3_acc_after_step2", 32'(alu_x), 32'h8000);
        send(16'h8000, 0);
        tick();

        // Test 4: len=0 produces an immediate zero result.
        push_exp(16'h0000, 1'b0, 1'b0);
        start_run(8'd0);
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        check("t4_res_valid_next", 32'(res_valid), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        tick();

        // Test 5: input gaps, then a held result while start is pulsed.
        push_exp(16'h3333, 1'b0, 1'b0);
        start_run(8'd2);
        send(16'h1111, 3);
        res_ready = 1'b0;
        send(16'h2222, 3);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len   = 8'd5;
            check("t5_hold_valid", 32'(res_valid), 32'd1);
            check("t5_hold_sum", 32'(res_sum), 32'h3333);
            check("t5_hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        start = 1'b0;
        check("t5_idle_after_ready", {30'd0, res_valid, busy}, 32'd0);
        repeat (3) tick();
        check("t5_no_new_run", {30'd0, in_ready, busy}, 32'd0);

        // Test 6: a mid-run reset, followed by a fresh single-operand run.
        start_run(8'd4);
        send(16'h0005, 0);
        check("t6_acc_before_reset", 32'(alu_x), 32'h0005);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_reset_outputs", {12'd0, res_sum, in_ready, res_valid, res_carry, res_ovf, res_zero, busy}, 32'd0);
        check("t6_reset_acc", 32'(alu_x), 32'd0);
        tick();
        push_exp(16'h1234, 1'b0, 1'b0);
        start_run(8'd1);
        send(16'h1234, 0);
        repeat (3) tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
